// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives one data-memory access per EX/MEM instruction
// over a req/gnt/rvalid bus, stalling the pipeline until the access completes or times out.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_cs_n,
  input  logic        in_mem_read,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_inc;
  logic        start, fault, go, done_ok, timeout;
  logic        op_ld, op_uns;
  logic [1:0]  op_size, op_off;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, rsh, ext;

  assign start = in_valid & ~in_cs_n;
  assign fault = (in_size == 2'b11) |
                 ((in_size == 2'b01) & in_addr[0]) |
                 ((in_size == 2'b10) & (|in_addr[1:0]));
  assign go    = (state == S_IDLE) & start & ~fault;

  // A load's grant is not a completion; it only moves on to waiting for data.
  assign cnt_inc = cnt + 8'd1;
  assign done_ok = ((state == S_REQ) & dmem_gnt & ~op_ld) | ((state == S_WAIT) & dmem_rvalid);
  assign timeout = ((state == S_REQ) | (state == S_WAIT)) & ~done_ok & (cnt_inc == MAX_CNT);

  assign out_stall = ~rst & (go | (state == S_REQ) | (state == S_WAIT));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (go) state_n = S_REQ;
      S_REQ: begin
        if (timeout)       state_n = S_DONE;
        else if (dmem_gnt) state_n = op_ld ? S_WAIT : S_DONE;
      end
      S_WAIT: if (timeout | dmem_rvalid) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = in_wdata;
    case (in_size)
      2'b00: begin
        be_n    = 4'b0001 << in_addr[1:0];
        wdata_n = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << in_addr[1:0];
        wdata_n = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rsh = dmem_rdata >> {op_off, 3'b000};

  always_comb begin
    ext = dmem_rdata;
    case (op_size)
      2'b00:   ext = {{24{rsh[7] & ~op_uns}}, rsh[7:0]};
      2'b01:   ext = {{16{rsh[15] & ~op_uns}}, rsh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      op_ld      <= 1'b0;
      op_uns     <= 1'b0;
      op_size    <= 2'b00;
      op_off     <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      load_valid <= (state_n == S_DONE);
      misaligned <= (state == S_IDLE) & start & fault;
      bus_err    <= timeout;
      if (go) begin
        cnt        <= 8'd0;
        op_ld      <= in_mem_read;
        op_uns     <= in_unsigned;
        op_size    <= in_size;
        op_off     <= in_addr[1:0];
        dmem_req   <= 1'b1;
        dmem_we    <= ~in_mem_read;
        dmem_be    <= be_n;
        dmem_addr  <= {in_addr[31:2], 2'b00};
        dmem_wdata <= wdata_n;
      end else if ((state == S_REQ) | (state == S_WAIT)) begin
        cnt <= cnt_inc;
      end
      if ((state == S_REQ) & (dmem_gnt | timeout)) dmem_req <= 1'b0;
      // Only a live WAIT consumes rdata; stray rvalid elsewhere is ignored.
      if (timeout)                               load_data <= 32'd0;
      else if ((state == S_WAIT) & dmem_rvalid)  load_data <= ext;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: each access is planned into per-cycle expectation
// tables from the bus timing, and a negedge process compares the DUT against them.
module tb_mem_stage_lsu;
  localparam int MW = 15;
  localparam int N  = 1024;

  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0, in_cs_n = 1, in_mem_read = 0, in_unsigned = 0;
  logic [1:0]  in_size = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        out_stall, dmem_req, dmem_we, load_valid, misaligned, bus_err;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cs_n(in_cs_n),
    .in_mem_read(in_mem_read), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .out_stall(out_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .load_data(load_data),
    .load_valid(load_valid), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          e_req[N], e_stall[N], e_lv[N], e_mis[N], e_berr[N], e_we[N], e_upd[N];
  logic [31:0] e_addr[N], e_wd[N], e_ldv[N];
  logic [3:0]  e_be[N];
  logic [31:0] cur_ld = 0;
  int          n_chk = 0, n_fail = 0;

  logic        pk_req, pk_lv, pk_mis, pk_berr, pk_stall, pk_we;
  logic [3:0]  pk_be;
  logic [31:0] pk_addr, pk_wd, pk_ld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [1:0] sz, input bit uns,
                                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * int'(a % 4));
    if (sz == 2'b00) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = d;
    return v;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < c + 64; i++) begin
      e_req[i%N] = 0; e_stall[i%N] = 0; e_lv[i%N] = 0;
      e_mis[i%N] = 0; e_berr[i%N] = 0; e_upd[i%N] = 0;
    end
  endtask

  // Timeline of one access starting in cycle b, derived from the bus handshake timing.
  task automatic plan(input int b, input bit ld, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd, input int g, input int r,
                      input logic [31:0] rd, output int e);
    int last;
    bit to;
    if (sz == 2'b11 || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)) begin
      e_mis[(b+1)%N] = 1;
      e = 1;
      return;
    end
    if (!ld) begin
      if (g <= MW) begin e = g + 1; last = g; to = 0; end
      else begin e = MW + 1; last = MW; to = 1; end
    end else if (g >= MW) begin
      e = MW + 1; last = MW; to = 1;
    end else begin
      last = g;
      if (r > g && r <= MW) begin e = r + 1; to = 0; end
      else begin e = MW + 1; to = 1; end
    end
    for (int i = 0; i < e; i++) e_stall[(b+i)%N] = 1;
    for (int i = 1; i <= last; i++) begin
      e_req[(b+i)%N]  = 1;
      e_we[(b+i)%N]   = !ld;
      e_addr[(b+i)%N] = a - (a % 4);
      e_be[(b+i)%N]   = (sz == 2'b00) ? 4'(1 << (a % 4)) : (sz == 2'b01) ? 4'(3 << (a % 4)) : 4'hF;
      e_wd[(b+i)%N]   = (sz == 2'b00) ? (wd % 256) * 32'h01010101 :
                        (sz == 2'b01) ? (wd % 65536) * 32'h00010001 : wd;
    end
    e_lv[(b+e)%N]   = 1;
    e_berr[(b+e)%N] = to;
    if (to) begin e_upd[(b+e)%N] = 1; e_ldv[(b+e)%N] = 0; end
    else if (ld) begin e_upd[(b+e)%N] = 1; e_ldv[(b+e)%N] = m_ext(sz, uns, a, rd); end
  endtask

  always @(negedge clk) begin
    int c;
    c = cyc % N;
    if (rst) begin
      cur_ld = 0;
      chk("rst_req", dmem_req, 0);     chk("rst_stall", out_stall, 0);
      chk("rst_we", dmem_we, 0);       chk("rst_be", dmem_be, 0);
      chk("rst_addr", dmem_addr, 0);   chk("rst_wdata", dmem_wdata, 0);
      chk("rst_ld", load_data, 0);     chk("rst_lv", load_valid, 0);
      chk("rst_mis", misaligned, 0);   chk("rst_berr", bus_err, 0);
    end else begin
      if (e_upd[c]) cur_ld = e_ldv[c];
      chk("req", dmem_req, e_req[c]);
      chk("stall", out_stall, e_stall[c]);
      chk("load_valid", load_valid, e_lv[c]);
      chk("misaligned", misaligned, e_mis[c]);
      chk("bus_err", bus_err, e_berr[c]);
      chk("load_data", load_data, cur_ld);
      if (e_req[c]) begin
        chk("addr", dmem_addr, e_addr[c]);
        chk("be", dmem_be, e_be[c]);
        chk("we", dmem_we, e_we[c]);
        chk("wdata", dmem_wdata, e_wd[c]);
      end
    end
  end

  task automatic run_access(input bit ld, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] wd, input int g,
                            input int r, input logic [31:0] rd, input int pk);
    int b, e, last;
    @(posedge clk); #1;
    b = cyc;
    plan(b, ld, sz, uns, a, wd, g, r, rd, e);
    in_valid = 1; in_cs_n = 0; in_mem_read = ld; in_size = sz; in_unsigned = uns;
    in_addr = a; in_wdata = wd; dmem_rdata = rd;
    last = e;
    if (g > last) last = g;
    if (r > last) last = r;
    last++;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      dmem_gnt = (k == g);
      dmem_rvalid = (k == r);
      if (k >= e) begin in_valid = 0; in_cs_n = 1; end
      if (k == pk) begin
        pk_req = dmem_req; pk_lv = load_valid; pk_mis = misaligned; pk_berr = bus_err;
        pk_stall = out_stall; pk_we = dmem_we; pk_be = dmem_be; pk_addr = dmem_addr;
        pk_wd = dmem_wdata; pk_ld = load_data;
      end
    end
    dmem_gnt = 0; dmem_rvalid = 0; in_valid = 0; in_cs_n = 1;
  endtask

  initial begin
    int b, e;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // word load: result appears in cycle 3
    run_access(1, 2'b10, 0, 32'h100, 0, 1, 2, 32'hDEADBEEF, 3);
    chk("w_ld_lv3", pk_lv, 1);
    chk("w_ld_data3", pk_ld, 32'hDEADBEEF);
    chk("w_ld_req3", pk_req, 0);

    run_access(1, 2'b00, 0, 32'h203, 0, 1, 2, 32'h80FFFFFF, 1);
    chk("b_ld_be", pk_be, 4'b1000);
    chk("b_ld_addr", pk_addr, 32'h200);
    chk("b_ld_sext", load_data, 32'hFFFFFF80);
    run_access(1, 2'b00, 1, 32'h203, 0, 1, 2, 32'h80FFFFFF, 0);
    chk("b_ld_zext", load_data, 32'h00000080);

    // half store, grant after three waiting cycles
    run_access(0, 2'b01, 0, 32'h402, 32'h12345678, 4, 0, 0, 3);
    chk("h_st_req", pk_req, 1);
    chk("h_st_wd", pk_wd, 32'h56785678);
    chk("h_st_be", pk_be, 4'b1100);
    chk("h_st_addr", pk_addr, 32'h400);
    chk("h_st_we", pk_we, 1);
    chk("h_st_keep_ld", load_data, 32'h00000080);

    run_access(1, 2'b10, 0, 32'h101, 0, 1, 2, 32'h11111111, 1);
    chk("mis_w_pulse", pk_mis, 1);
    chk("mis_w_noreq", pk_req, 0);
    run_access(1, 2'b11, 0, 32'h100, 0, 1, 2, 32'h11111111, 1);
    chk("mis_sz3_pulse", pk_mis, 1);
    run_access(0, 2'b01, 0, 32'h201, 32'hFFFF, 1, 0, 0, 1);
    chk("mis_h_pulse", pk_mis, 1);

    run_access(1, 2'b01, 0, 32'h302, 0, 2, 5, 32'h80011234, 0);
    chk("h_ld_sext", load_data, 32'hFFFF8001);
    run_access(0, 2'b10, 0, 32'h500, 32'hCAFEF00D, 1, 0, 0, 1);
    chk("w_st_wd", pk_wd, 32'hCAFEF00D);
    chk("w_st_be", pk_be, 4'b1111);
    run_access(0, 2'b00, 0, 32'h601, 32'h000000A5, 2, 0, 0, 1);
    chk("b_st_be", pk_be, 4'b0010);
    chk("b_st_wd", pk_wd, 32'hA5A5A5A5);

    // rvalid never arrives in time; the late one at cycle 20 must be ignored
    run_access(1, 2'b10, 0, 32'h700, 0, 1, 20, 32'hFFFFFFFF, 16);
    chk("to_berr16", pk_berr, 1);
    chk("to_lv16", pk_lv, 1);
    chk("to_ld16", pk_ld, 0);
    chk("to_stall16", pk_stall, 0);
    chk("to_late_rvalid", load_data, 0);

    // give load_data a nonzero value so the reset clear is visible
    run_access(1, 2'b10, 0, 32'h104, 0, 1, 2, 32'h0BADF00D, 0);
    @(posedge clk); #1;
    b = cyc;
    plan(b, 1, 2'b10, 0, 32'h800, 0, 1, 0, 0, e);
    in_valid = 1; in_cs_n = 0; in_mem_read = 1; in_size = 2'b10; in_addr = 32'h800;
    @(posedge clk); #1 dmem_gnt = 1;
    @(posedge clk); #1 dmem_gnt = 0;
    @(posedge clk); #1;
    chk("wait_req_low", dmem_req, 0);
    chk("wait_stall", out_stall, 1);
    #1;
    rst = 1;
    clear_from(b + 3);
    in_valid = 0; in_cs_n = 1;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", out_stall, 0);
    chk("arst_ld", load_data, 0);
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1 dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1 dmem_rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ld", load_data, 0);
    chk("post_rst_lv", load_valid, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
